// File: rtl/adder_rr_scheduler.sv
// -----------------------------------------------------------------------------
// adder_rr_scheduler
//
// Shares one W-bit adder ({cout,sum} = a + b + cin) between NREQ requesters.
// A round-robin arbiter picks one requester per cycle. The result goes into a
// registered single-entry slot that has valid/ready backpressure. A requester
// can take a chain lock and issue a multi-word add. While the lock is held,
// the carry-out of each beat becomes the carry-in of the next beat.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   req_valid  in   NREQ     requester i presents an add operation
//   req_ready  out  NREQ     one-hot grant; op i accepted on valid[i]&ready[i]
//   req_a      in   NREQ*W   operand A, requester i at [i*W +: W]
//   req_b      in   NREQ*W   operand B, same packing
//   req_cin    in   NREQ     carry-in (ignored while chain-locked)
//   req_chain  in   NREQ     1 = more beats follow; hold lock, keep carry
//   rsp_valid  out  1        result slot occupied
//   rsp_ready  in   1        consumer takes result on rsp_valid&rsp_ready
//   rsp_id     out  IDW      requester index of the result
//   rsp_sum    out  W        sum bits
//   rsp_cout   out  1        carry-out (bit W of the W+1-bit add)
// -----------------------------------------------------------------------------
module adder_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    input  logic [NREQ-1:0]         req_cin,
    input  logic [NREQ-1:0]         req_chain,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_sum,
    output logic                    rsp_cout
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] owner;
    logic           carry_q;

    logic           slot_free;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;
    logic           accept;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           cin_eff;
    logic [W:0]     add_res;

    // The slot can take a new result when it is empty or when it drains this cycle.
    assign slot_free = !rsp_valid || rsp_ready;

    // Grant selection. The scan runs from the farthest candidate down to rr_ptr.
    // The last match written is the one nearest to rr_ptr, so that candidate wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if (state == LOCKED) begin
            grant_found = req_valid[owner];
            grant_idx   = owner;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
                if (req_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

    assign accept = grant_found && slot_free;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Shared datapath. The add is W+1 bits wide, so the carry-out is kept.
    assign a_sel   = req_a[grant_idx*W +: W];
    assign b_sel   = req_b[grant_idx*W +: W];
    assign cin_eff = (state == LOCKED) ? carry_q : req_cin[grant_idx];
    assign add_res = {1'b0, a_sel} + {1'b0, b_sel} + {{W{1'b0}}, cin_eff};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the clock edge.
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            carry_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else if (accept) begin
            // A drain and an accept in the same cycle just reload the slot.
            rsp_valid <= 1'b1;
            rsp_id    <= grant_idx;
            rsp_sum   <= add_res[W-1:0];
            rsp_cout  <= add_res[W];
            if (req_chain[grant_idx]) begin
                state   <= LOCKED;
                owner   <= grant_idx;
                carry_q <= add_res[W];
            end else begin
                state  <= IDLE;
                rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
